// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access scheduler.
// Contents: scheduler state encoding, idle level of the RTC control lines,
// and a counter-width helper that keeps single-value counters at least one bit wide.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LEER     = 2'd1,
        ST_ESCRIBIR = 2'd2,
        ST_GAP      = 2'd3
    } state_e;

    // RTC control lines are active-low; idle is all ones.
    localparam logic BUS_IDLE = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rtc_access_scheduler_if.sv
// Bundle between the scheduler, the read/write sequencers and the RTC pins.
// slave : scheduler side (takes requests and sequencer lines, drives enables,
//         muxed RTC lines, busy flag and completion pulses).
// master: environment side (the reverse).
interface rtc_access_scheduler_if;
    logic req_escribir;
    logic req_leer;
    logic a_d_l, cs_l, rd_l, wr_l;
    logic a_d_e, cs_e, rd_e, wr_e;
    logic do_it_leer;
    logic do_it_escribir;
    logic a_d, cs, rd, wr;
    logic ocupado;
    logic fin_leer;
    logic fin_escribir;

    modport slave (
        input  req_escribir, req_leer,
        input  a_d_l, cs_l, rd_l, wr_l,
        input  a_d_e, cs_e, rd_e, wr_e,
        output do_it_leer, do_it_escribir,
        output a_d, cs, rd, wr,
        output ocupado, fin_leer, fin_escribir
    );

    modport master (
        output req_escribir, req_leer,
        output a_d_l, cs_l, rd_l, wr_l,
        output a_d_e, cs_e, rd_e, wr_e,
        input  do_it_leer, do_it_escribir,
        input  a_d, cs, rd, wr,
        input  ocupado, fin_leer, fin_escribir
    );
endinterface

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh timer: counts 0..PERIOD-1 and wraps to 0.
// Ports: clk, reset (async, active-high), wrap_c (high during the last count,
// i.e. in the cycle whose closing edge wraps the counter).
module rtc_refresh_timer
    import rtc_pkg::*;
#(
    parameter int unsigned PERIOD = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic wrap_c
);

    localparam int unsigned TW = cnt_width(PERIOD);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap_c = (cnt_q == TW'(PERIOD - 1));
        cnt_d  = wrap_c ? '0 : cnt_q + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rtc_access_scheduler.sv
// Arbitrates RTC access between a read sequencer and a write sequencer.
// Write requests win over reads; a running sweep is never preempted; every
// sweep is followed by GAP_CYCLES idle cycles. Reads are also requested
// automatically by the refresh timer.
// Ports: clk, reset (async, active-high), bus (rtc_access_scheduler_if.slave):
//   req_escribir/req_leer request pulses, *_l/*_e sequencer RTC lines,
//   do_it_leer/do_it_escribir sequencer enables, a_d/cs/rd/wr muxed RTC lines,
//   ocupado busy flag, fin_leer/fin_escribir completion pulses.
module rtc_access_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned READ_CYCLES    = 351,
    parameter int unsigned WRITE_CYCLES   = 351,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned REFRESH_PERIOD = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    rtc_access_scheduler_if.slave  bus
);

    localparam int unsigned MAX_SWEEP = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int unsigned SW        = cnt_width(MAX_SWEEP);
    localparam int unsigned GW        = cnt_width(GAP_CYCLES);

    state_e        state_q, state_d;
    logic [SW-1:0] sweep_q, sweep_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pend_w_q, pend_w_d;
    logic          pend_r_q, pend_r_d;
    logic          do_l_q, do_l_d;
    logic          do_e_q, do_e_d;
    logic          fin_l_q, fin_l_d;
    logic          fin_e_q, fin_e_d;
    logic          ocup_q, ocup_d;
    logic          refresh_wrap_c;
    logic [SW-1:0] sweep_last_c;

    rtc_refresh_timer #(
        .PERIOD (REFRESH_PERIOD)
    ) u_refresh (
        .clk    (clk),
        .reset  (reset),
        .wrap_c (refresh_wrap_c)
    );

    // Next-state, pending-flag and registered-output logic.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        gap_d    = gap_q;
        fin_l_d  = 1'b0;
        fin_e_d  = 1'b0;
        // A request in the cycle its flag is consumed re-arms the flag.
        pend_w_d = pend_w_q | bus.req_escribir;
        pend_r_d = pend_r_q | bus.req_leer | refresh_wrap_c;
        sweep_last_c = (state_q == ST_ESCRIBIR) ? SW'(WRITE_CYCLES - 1) : SW'(READ_CYCLES - 1);

        case (state_q)
            ST_IDLE: begin
                if (pend_w_q) begin
                    state_d  = ST_ESCRIBIR;
                    sweep_d  = '0;
                    pend_w_d = bus.req_escribir;
                end else if (pend_r_q) begin
                    state_d  = ST_LEER;
                    sweep_d  = '0;
                    pend_r_d = bus.req_leer | refresh_wrap_c;
                end
            end
            ST_LEER, ST_ESCRIBIR: begin
                if (sweep_q == sweep_last_c) begin
                    fin_l_d = (state_q == ST_LEER);
                    fin_e_d = (state_q == ST_ESCRIBIR);
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    sweep_d = sweep_q + SW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                              gap_d   = gap_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        do_l_d = (state_d == ST_LEER);
        do_e_d = (state_d == ST_ESCRIBIR);
        ocup_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sweep_q  <= '0;
            gap_q    <= '0;
            pend_w_q <= 1'b0;
            pend_r_q <= 1'b0;
            do_l_q   <= 1'b0;
            do_e_q   <= 1'b0;
            fin_l_q  <= 1'b0;
            fin_e_q  <= 1'b0;
            ocup_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            gap_q    <= gap_d;
            pend_w_q <= pend_w_d;
            pend_r_q <= pend_r_d;
            do_l_q   <= do_l_d;
            do_e_q   <= do_e_d;
            fin_l_q  <= fin_l_d;
            fin_e_q  <= fin_e_d;
            ocup_q   <= ocup_d;
        end
    end

    assign bus.do_it_leer     = do_l_q;
    assign bus.do_it_escribir = do_e_q;
    assign bus.ocupado        = ocup_q;
    assign bus.fin_leer       = fin_l_q;
    assign bus.fin_escribir   = fin_e_q;

    // Pin mux keyed on the registered enables, so reset idles the pins at once.
    assign bus.a_d = do_l_q ? bus.a_d_l : (do_e_q ? bus.a_d_e : BUS_IDLE);
    assign bus.cs  = do_l_q ? bus.cs_l  : (do_e_q ? bus.cs_e  : BUS_IDLE);
    assign bus.rd  = do_l_q ? bus.rd_l  : (do_e_q ? bus.rd_e  : BUS_IDLE);
    assign bus.wr  = do_l_q ? bus.wr_l  : (do_e_q ? bus.wr_e  : BUS_IDLE);

endmodule
